// File: rtl/tdm_demux_pkg.sv
// Shared constants and types for the 4-channel TDM demultiplexer.
package tdm_demux_pkg;

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef logic [CH_W-1:0] ch_idx_t;

endpackage : tdm_demux_pkg

// File: rtl/tdm_demux_slot.sv
// One-entry output register slice for a single demux channel.
// A load takes priority over a drain, so a simultaneous load and drain
// replaces the data and keeps valid high.
module tdm_demux_slot #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             ready_in,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Slot occupancy and data: load wins, otherwise a drain empties the slot
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load) begin
      valid_q <= 1'b1;
      data_q  <= data_in;
    end else if (ready_in) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;

endmodule : tdm_demux_slot

// File: rtl/tdm_demux_4ch.sv
// Four-channel time-division demultiplexer: distributes a serialized sample
// stream round-robin to four valid/ready output channels, with s_sof
// realigning the stream to channel 0.
// Optional feature macro: TDM_SYNC_CHECK_EN adds the sync_err / err_cnt
// frame-misalignment checker.
module tdm_demux_4ch
  import tdm_demux_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [WIDTH-1:0]        s_data,
  input  logic                    s_sof,
  output logic [NUM_CH-1:0]       m_valid,
  input  logic [NUM_CH-1:0]       m_ready,
  output logic [NUM_CH*WIDTH-1:0] m_data
`ifdef TDM_SYNC_CHECK_EN
  ,
  output logic                    sync_err,
  output logic [7:0]              err_cnt
`endif
);

  ch_idx_t             ch_sel_q;
  ch_idx_t             ch_sel_d;
  ch_idx_t             dest;
  logic                accept;
  logic [NUM_CH-1:0]   load;

  // s_sof forces the beat to channel 0 regardless of the pointer
  assign dest    = s_sof ? '0 : ch_sel_q;
  assign s_ready = !m_valid[dest] || m_ready[dest];
  assign accept  = s_valid && s_ready;

  // Next pointer and per-slot load strobes
  always_comb begin
    ch_sel_d = ch_sel_q;
    load     = '0;
    if (accept) begin
      ch_sel_d = ch_idx_t'(dest + 1'b1);
    end
    for (int unsigned n = 0; n < NUM_CH; n++) begin
      load[n] = accept && (dest == ch_idx_t'(n));
    end
  end

  // Round-robin destination pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_sel_q <= '0;
    end else begin
      ch_sel_q <= ch_sel_d;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_slot
    tdm_demux_slot #(
      .WIDTH (WIDTH)
    ) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[g]),
      .data_in   (s_data),
      .ready_in  (m_ready[g]),
      .valid_out (m_valid[g]),
      .data_out  (m_data[g*WIDTH +: WIDTH])
    );
  end

`ifdef TDM_SYNC_CHECK_EN
  logic       misalign;
  logic       sync_err_q;
  logic [7:0] err_cnt_q;

  assign misalign = accept && s_sof && (ch_sel_q != '0);

  // Misalignment pulse and saturating error count, updated together
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_err_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      sync_err_q <= misalign;
      if (misalign && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign sync_err = sync_err_q;
  assign err_cnt  = err_cnt_q;
`else
  // No checker: s_sof realigns the pointer silently.
`endif

endmodule : tdm_demux_4ch

// File: tb/tb_tdm_demux_4ch.sv
// Scoreboard bench for tdm_demux_4ch: a predictor pushes expected samples
// per channel on each predicted acceptance, a monitor pops and compares on
// every output drain; directed hand-computed checks cover routing and stalls.
module tb_tdm_demux_4ch;

  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_valid;
  logic           s_ready;
  logic [W-1:0]   s_data;
  logic           s_sof;
  logic [3:0]     m_valid;
  logic [3:0]     m_ready;
  logic [4*W-1:0] m_data;
`ifdef TDM_SYNC_CHECK_EN
  logic           sync_err;
  logic [7:0]     err_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] exp_q [4][$];
  logic [W-1:0] rx_log[4][$];
  logic [1:0]   ch_sel_m = 2'd0;
  logic [1:0]   pred_dest;
  logic [1:0]   mon_dest;
  logic         mon_rdy_exp;

  tdm_demux_4ch #(
    .WIDTH (W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_sof    (s_sof),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .m_data   (m_data)
`ifdef TDM_SYNC_CHECK_EN
    ,
    .sync_err (sync_err),
    .err_cnt  (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] last_rx(input int n);
    if (rx_log[n].size() == 0) return 'x;
    return rx_log[n][rx_log[n].size()-1];
  endfunction

  // Monitor: compare outputs against the expected queues, pop on drain
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      mon_dest    = s_sof ? 2'd0 : ch_sel_m;
      mon_rdy_exp = (exp_q[mon_dest].size() == 0) || m_ready[mon_dest];
      chk("s_ready", s_ready, mon_rdy_exp);
      for (int n = 0; n < 4; n++) begin
        chk($sformatf("m_valid[%0d]", n), m_valid[n], exp_q[n].size() != 0);
        if (m_valid[n] && exp_q[n].size() != 0) begin
          chk($sformatf("m_data[%0d]", n), m_data[n*W +: W], exp_q[n][0]);
          if (m_ready[n]) begin
            rx_log[n].push_back(m_data[n*W +: W]);
            void'(exp_q[n].pop_front());
          end
        end
      end
    end
  end

  // Predictor: runs after the monitor has retired this cycle's drains
  always @(negedge clk) begin
    #1;
    if (rst !== 1'b0) begin
      for (int n = 0; n < 4; n++) exp_q[n].delete();
      ch_sel_m = 2'd0;
    end else if (s_valid) begin
      pred_dest = s_sof ? 2'd0 : ch_sel_m;
      if (exp_q[pred_dest].size() == 0) begin
        exp_q[pred_dest].push_back(s_data);
        ch_sel_m = pred_dest + 2'd1;
      end
    end
  end

  task automatic send(input logic [W-1:0] d, input logic sof, output int waits);
    s_valid = 1'b1;
    s_data  = d;
    s_sof   = sof;
    waits   = 0;
    @(negedge clk);
    while (!s_ready && waits < 50) begin
      waits++;
      @(negedge clk);
    end
    if (!s_ready) chk("send_timeout", waits, 0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0;
    s_sof   = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int wsum;
    rst = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_data = '0; m_ready = 4'hF;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 4'h0);
    chk("rst_m_data", m_data, 64'h0);
`ifdef TDM_SYNC_CHECK_EN
    chk("rst_sync_err", sync_err, 1'b0);
    chk("rst_err_cnt", err_cnt, 8'd0);
`endif

    // Eight aligned beats, all channels ready
    wsum = 0;
    for (int i = 0; i < 8; i++) begin
      send(W'(i + 1), i == 0, w);
      wsum += w;
    end
    idle(3);
    chk("p1_no_stall", wsum, 0);
    chk("p1_ch0_count", rx_log[0].size(), 2);
    chk("p1_ch0_first", rx_log[0][0], 16'h0001);
    chk("p1_ch0_second", rx_log[0][1], 16'h0005);
    chk("p1_ch3_first", rx_log[3][0], 16'h0004);
    chk("p1_ch3_second", rx_log[3][1], 16'h0008);

    // Channel 2 stalled: other lanes keep flowing until ch2 is the destination again
    m_ready = 4'b1011;
    wsum = 0;
    for (int i = 0; i < 6; i++) begin
      send(W'(16'h11 + i), i == 0, w);
      wsum += w;
    end
    chk("p2_other_lanes_flow", wsum, 0);
    s_valid = 1'b1; s_data = 16'h0017; s_sof = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("p2_s_ready_low", s_ready, 1'b0);
      @(posedge clk);
      #1;
    end
    m_ready[2] = 1'b1;
    @(negedge clk);
    chk("p2_s_ready_release", s_ready, 1'b1);
    chk("p2_old_ch2_data", m_data[2*W +: W], 16'h0013);
    @(posedge clk);
    #1;
    chk("p2_ch2_valid_kept", m_valid[2], 1'b1);
    chk("p2_new_ch2_data", m_data[2*W +: W], 16'h0017);
    idle(3);
    chk("p2_ch0_last", last_rx(0), 16'h0015);
    chk("p2_ch1_last", last_rx(1), 16'h0016);
    chk("p2_ch3_last", last_rx(3), 16'h0014);
    chk("p2_ch2_last", last_rx(2), 16'h0017);

    // Misaligned s_sof at pointer 2
    send(16'h0021, 1'b0, w);
    send(16'h0022, 1'b0, w);
    send(16'h0023, 1'b0, w);
    send(16'h00AA, 1'b1, w);
    chk("p3_sof_valid_ch0", m_valid[0], 1'b1);
    chk("p3_sof_data_ch0", m_data[0 +: W], 16'h00AA);
`ifdef TDM_SYNC_CHECK_EN
    chk("p3_sync_err_pulse", sync_err, 1'b1);
    chk("p3_err_cnt_one", err_cnt, 8'd1);
`endif
    send(16'h0030, 1'b0, w);
    chk("p3_next_to_ch1", m_data[1*W +: W], 16'h0030);
    chk("p3_next_valid_ch1", m_valid[1], 1'b1);
`ifdef TDM_SYNC_CHECK_EN
    chk("p3_sync_err_cleared", sync_err, 1'b0);
    chk("p3_err_cnt_held", err_cnt, 8'd1);
`endif
    idle(2);

    // Reset with slots 0 and 1 occupied
    m_ready = 4'h0;
    send(16'h0041, 1'b1, w);
    send(16'h0042, 1'b0, w);
    idle(1);
    chk("p4_pending", m_valid, 4'b0011);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("p4_rst_m_valid", m_valid, 4'h0);
    chk("p4_rst_m_data", m_data, 64'h0);
`ifdef TDM_SYNC_CHECK_EN
    chk("p4_rst_err_cnt", err_cnt, 8'd0);
    chk("p4_rst_sync_err", sync_err, 1'b0);
`endif
    m_ready = 4'hF;
    send(16'h0051, 1'b0, w);
    chk("p4_first_beat_ch0_valid", m_valid, 4'b0001);
    chk("p4_first_beat_ch0_data", m_data[0 +: W], 16'h0051);

    // 300 misaligned s_sof beats back to back
    wsum = 0;
    for (int i = 0; i < 300; i++) begin
      send(W'(16'h0100 + i), 1'b1, w);
      wsum += w;
    end
`ifdef TDM_SYNC_CHECK_EN
    chk("p5_err_cnt_sat", err_cnt, 8'd255);
    chk("p5_sync_err_still", sync_err, 1'b1);
`endif
    idle(3);
    chk("p5_full_rate", wsum, 0);
    chk("p5_ch0_last", last_rx(0), 16'h022B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux_4ch

// File: doc/tdm_demux_4ch.md
# tdm_demux_4ch

Four-channel time-division demultiplexer: accepts one serialized sample stream with a start-of-frame marker and distributes successive samples round-robin to four independent output channels. Each channel has its own valid/ready handshake. It is the receive-side counterpart of the team's 4:1 channel-select multiplexing, and sits between the serialized SDR sample path and the per-channel processing lanes.

## Interface
Parameters:
- WIDTH, 16, sample width in bits.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_data  in  WIDTH  input sample.
- s_sof  in  1  start-of-frame; the sample on this beat belongs to channel 0.
- m_valid  out  4  per-channel output valid; bit n is channel n.
- m_ready  in  4  per-channel output ready.
- m_data  out  4*WIDTH  channel n occupies bits [n*WIDTH +: WIDTH].
- sync_err  out  1  present only with TDM_SYNC_CHECK_EN.
- err_cnt  out  8  present only with TDM_SYNC_CHECK_EN.

## Operation
- ch_sel: 2-bit round-robin pointer; it selects the destination slot for the next accepted beat.
- Effective destination on an accepted beat: 0 if s_sof=1, otherwise ch_sel.
- After an accepted beat, ch_sel becomes destination+1 modulo 4 (3 wraps to 0). With no accepted beat, ch_sel holds.
- Each channel has a one-entry output slot holding m_valid[n] and its data.
- Slot n drains when m_valid[n] && m_ready[n]; its valid then clears unless a new load happens in the same cycle.
- s_ready = !m_valid[dest] || m_ready[dest], where dest is the effective destination computed combinationally from s_sof and ch_sel.
- A simultaneous drain and load of the same slot is allowed. The new data replaces the old data and valid stays 1.
- Loads and drains on different slots are fully independent in the same cycle.
- There is no reordering; within a channel, samples leave in arrival order.
- A stalled channel blocks the input only when that channel is the current destination. Other channels keep draining.
- s_data and s_sof are ignored when s_valid=0.

## Timing
- Reset values: m_valid=0, m_data=0, ch_sel=0, sync_err=0, err_cnt=0.
- Reset in the middle of operation discards every pending slot. s_ready is don't-care during rst.
- Latency: a beat accepted in cycle t gives m_valid[dest]=1 with the data in cycle t+1.
- Throughput: one sample per clock while the destination slots are drained.
- s_ready is combinational from s_sof, m_valid and m_ready. There is no combinational path from s_valid to s_ready.
- m_valid and m_data are registered outputs.

## Configuration
- Macro: TDM_SYNC_CHECK_EN.
- With the macro defined, sync_err pulses high for exactly one cycle, in the cycle after an accepted beat with s_sof=1 while ch_sel≠0 (frame misalignment).
  - err_cnt increments on each sync_err pulse and saturates at 255.
  - Realignment to channel 0 still occurs on that beat.
- Without the macro, the sync_err and err_cnt ports and their logic are absent. s_sof still realigns silently.

## Structure
- Package tdm_demux_pkg holds:
  - NUM_CH=4;
  - CH_W=2;
  - typedef ch_idx_t, a logic vector of CH_W bits.
- One sub-module, tdm_demux_slot: a one-entry register slice with load, data_in, ready_in, valid_out and data_out. It is instantiated NUM_CH times.
- The top level contains ch_sel, the destination decode, s_ready and the optional sync checker.

## Test plan
- Reset, then 8 beats with s_sof on beat 0 and data 0x0001..0x0008, all m_ready=1:
  - channel 0 receives 0x0001 then 0x0005; channel 3 receives 0x0004 then 0x0008;
  - each output appears one cycle after acceptance;
  - s_ready stays 1 throughout.
- Hold m_ready[2]=0 and stream 6 beats:
  - s_ready drops when the destination is channel 2 while slot 2 is full;
  - it stays low until m_ready[2]=1, and with m_ready[2]=1 the load and the drain happen in the same cycle;
  - channels 0, 1 and 3 keep draining meanwhile.
- Assert s_sof on the beat with ch_sel=2, data 0x00AA:
  - 0x00AA appears on channel 0 and the next beat goes to channel 1;
  - with TDM_SYNC_CHECK_EN, sync_err pulses once and err_cnt=1.
- Assert rst while slots 0 and 1 hold valid data:
  - next cycle m_valid=0000, ch_sel=0 and err_cnt=0;
  - the first beat after reset lands on channel 0.
- With the macro, inject 300 misaligned s_sof beats: err_cnt saturates at 255 and sync_err keeps pulsing.
